// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit in the EX stage (shift-add multiply, restoring divide).
// Optional macro MULDIV_FAST_MUL_EN: multiplies complete in one step via a 33x33 signed multiplier.
`timescale 1ns/1ps
module ex_muldiv #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic            reg_wen_o
);
    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    state_t r_state, w_next;

    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_hi, r_lo, r_mcand, r_rd_data;
    logic [2:0]      r_f3;
    logic            r_neg;
    logic [4:0]      r_rd, r_rd_addr;

    logic            w_is_mop, w_is_div, w_sgn1, w_sgn2, w_neg1, w_neg2, w_neg_res;
    logic [2:0]      w_f3;
    logic [XLEN-1:0] w_abs1, w_abs2;
    logic            w_div_zero, w_div_ovf, w_special, w_fast, w_instant;
    logic [XLEN-1:0] w_special_data, w_fast_data, w_instant_data;
    logic            w_fast_unused, w_unused;

    assign w_is_mop  = (inst_i[6:0] == 7'b0110011) && (inst_i[31:25] == 7'b0000001);
    assign w_f3      = inst_i[14:12];
    assign w_is_div  = w_f3[2];
    assign w_sgn1    = (w_f3 == 3'b001) || (w_f3 == 3'b010) || (w_f3 == 3'b100) || (w_f3 == 3'b110);
    assign w_sgn2    = (w_f3 == 3'b001) || (w_f3 == 3'b100) || (w_f3 == 3'b110);
    assign w_neg1    = w_sgn1 & op1_i[XLEN-1];
    assign w_neg2    = w_sgn2 & op2_i[XLEN-1];
    assign w_abs1    = w_neg1 ? -op1_i : op1_i;
    assign w_abs2    = w_neg2 ? -op2_i : op2_i;
    // Remainder takes the dividend's sign; every other result takes sign(op1) ^ sign(op2).
    assign w_neg_res = (w_is_div && w_f3[1]) ? w_neg1 : (w_neg1 ^ w_neg2);

    assign w_div_zero = w_is_div && (op2_i == '0);
    assign w_div_ovf  = w_is_div && !w_f3[0] && (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
    assign w_special  = w_div_zero | w_div_ovf;

    always_comb begin
        w_special_data = '1;
        if (w_div_zero)
            w_special_data = w_f3[1] ? op1_i : '1;
        else if (w_div_ovf)
            w_special_data = w_f3[1] ? '0 : op1_i;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN+1:0] w_fast_prod;
    assign w_fast_prod   = $signed({w_sgn1 & op1_i[XLEN-1], op1_i}) * $signed({w_sgn2 & op2_i[XLEN-1], op2_i});
    assign w_fast        = !w_is_div;
    assign w_fast_data   = (w_f3 == 3'b000) ? w_fast_prod[XLEN-1:0] : w_fast_prod[2*XLEN-1:XLEN];
    assign w_fast_unused = ^w_fast_prod[2*XLEN+1:2*XLEN];
`else
    assign w_fast        = 1'b0;
    assign w_fast_data   = '0;
    assign w_fast_unused = 1'b0;
`endif

    assign w_instant      = w_special | w_fast;
    assign w_instant_data = w_special ? w_special_data : w_fast_data;

    // One iteration: multiply shifts {sum, lo} right; divide shifts {hi, lo} left and trial-subtracts.
    logic [XLEN:0]   w_mul_sum, w_rem_sh;
    logic [XLEN+1:0] w_diff;
    logic            w_div_ok;
    logic [XLEN-1:0] w_step_hi, w_step_lo, w_quo_s, w_rem_s, w_iter_data;
    logic [2*XLEN-1:0] w_prod_s;

    assign w_mul_sum = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_mcand}) : {1'b0, r_hi};
    assign w_rem_sh  = {r_hi, r_lo[XLEN-1]};
    assign w_diff    = {1'b0, w_rem_sh} - {2'b00, r_mcand};
    assign w_div_ok  = !w_diff[XLEN+1];
    assign w_step_hi = r_f3[2] ? (w_div_ok ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0]) : w_mul_sum[XLEN:1];
    assign w_step_lo = r_f3[2] ? {r_lo[XLEN-2:0], w_div_ok} : {w_mul_sum[0], r_lo[XLEN-1:1]};
    assign w_prod_s  = r_neg ? -{w_step_hi, w_step_lo} : {w_step_hi, w_step_lo};
    assign w_quo_s   = r_neg ? -w_step_lo : w_step_lo;
    assign w_rem_s   = r_neg ? -w_step_hi : w_step_hi;

    always_comb begin
        w_iter_data = w_rem_s;
        case (r_f3)
            3'b000:                 w_iter_data = w_prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_iter_data = w_prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_iter_data = w_quo_s;
            default:                w_iter_data = w_rem_s;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Stall and write enable are gated by rst so outputs read as reset while it is held.
    always_comb begin
        w_next    = r_state;
        stall_o   = 1'b0;
        reg_wen_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_is_mop && !flush_i) begin
                    stall_o = !rst;
                    w_next  = w_instant ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                stall_o = !rst;
                if (flush_i)                w_next = S_IDLE;
                else if (r_cnt == CW'(1))   w_next = S_DONE;
            end
            S_DONE: begin
                reg_wen_o = !flush_i && !rst;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_mcand   <= '0;
            r_f3      <= '0;
            r_neg     <= 1'b0;
            r_rd      <= '0;
            r_rd_addr <= '0;
            r_rd_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_next == S_BUSY) begin
                        r_cnt   <= CW'(ITER);
                        r_hi    <= '0;
                        r_lo    <= w_is_div ? w_abs1 : w_abs2;
                        r_mcand <= w_is_div ? w_abs2 : w_abs1;
                        r_f3    <= w_f3;
                        r_neg   <= w_neg_res;
                        r_rd    <= rd_addr_i;
                    end else if (w_next == S_DONE) begin
                        r_rd_data <= w_instant_data;
                        r_rd_addr <= rd_addr_i;
                    end
                end
                S_BUSY: begin
                    if (flush_i) begin
                        r_cnt <= '0;
                    end else begin
                        r_hi  <= w_step_hi;
                        r_lo  <= w_step_lo;
                        r_cnt <= r_cnt - CW'(1);
                        if (w_next == S_DONE) begin
                            r_rd_data <= w_iter_data;
                            r_rd_addr <= r_rd;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o    = (r_state != S_IDLE);
    assign rd_addr_o = r_rd_addr;
    assign rd_data_o = r_rd_data;

    assign w_unused = ^{inst_i[24:15], inst_i[11:7], w_diff[XLEN], w_fast_unused};
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv: multiply, divide, special cases, flush, reset and back-to-back ops.
`timescale 1ns/1ps
module tb_ex_muldiv;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_i, op1_i, op2_i;
    logic [4:0]  rd_addr_i;
    logic        flush_i;
    logic        stall_o, busy_o, reg_wen_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [6:0]  F7M = 7'b0000001;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    ex_muldiv #(.XLEN(32), .ITER(32)) dut (
        .clk(clk), .rst(rst), .inst_i(inst_i), .op1_i(op1_i), .op2_i(op2_i),
        .rd_addr_i(rd_addr_i), .flush_i(flush_i), .stall_o(stall_o), .busy_o(busy_o),
        .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .reg_wen_o(reg_wen_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    function automatic string opname(input logic [2:0] f3);
        case (f3)
            3'b000: return "MUL";
            3'b001: return "MULH";
            3'b010: return "MULHSU";
            3'b011: return "MULHU";
            3'b100: return "DIV";
            3'b101: return "DIVU";
            3'b110: return "REM";
            default: return "REMU";
        endcase
    endfunction

    // Presents one M-op just after a falling edge and measures write-back latency, data and stall length.
    task automatic issue_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, output int lat, output logic [31:0] data,
                            output logic [4:0] rdo, output int stalls);
        lat = -1; data = '0; rdo = '0; stalls = 0;
        inst_i = rtype(F7M, f3, rd); op1_i = a; op2_i = b; rd_addr_i = rd;
        #1;
        if (stall_o) stalls++;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clk); #1;
            if (stall_o) stalls++;
            if (reg_wen_o) begin lat = k; data = rd_data_o; rdo = rd_addr_o; end
        end
        inst_i = NOP;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush_i = 1'b0; inst_i = NOP; op1_i = '0; op2_i = '0; rd_addr_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (stall_o !== 1'b0)   begin n_fail++; $display("FAIL reset stall_o: got %b expected 0", stall_o); end
        n_cmp++; if (busy_o !== 1'b0)    begin n_fail++; $display("FAIL reset busy_o: got %b expected 0", busy_o); end
        n_cmp++; if (reg_wen_o !== 1'b0) begin n_fail++; $display("FAIL reset reg_wen_o: got %b expected 0", reg_wen_o); end
        n_cmp++; if (rd_addr_o !== 5'd0) begin n_fail++; $display("FAIL reset rd_addr_o: got %0d expected 0", rd_addr_o); end
        n_cmp++; if (rd_data_o !== 32'd0) begin n_fail++; $display("FAIL reset rd_data_o: got %h expected 0", rd_data_o); end
    endtask

    task automatic test_mul();
        vec_t v[6];
        int lat, stalls; logic [31:0] d; logic [4:0] r;
        v[0] = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT};
        v[1] = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT};
        v[2] = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT};
        v[3] = '{3'b001, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, MUL_LAT};
        v[4] = '{3'b001, 32'h40000000, 32'd4,        32'h00000001, MUL_LAT};
        v[5] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            issue_op(v[i].f3, v[i].a, v[i].b, 5'(5 + i), lat, d, r, stalls);
            n_cmp++; if (d !== v[i].exp) begin n_fail++; $display("FAIL %s[%0d] data: got %h expected %h", opname(v[i].f3), i, d, v[i].exp); end
            n_cmp++; if (r !== 5'(5 + i)) begin n_fail++; $display("FAIL %s[%0d] rd: got %0d expected %0d", opname(v[i].f3), i, r, 5 + i); end
            n_cmp++; if (lat != v[i].lat) begin n_fail++; $display("FAIL %s[%0d] latency: got %0d expected %0d", opname(v[i].f3), i, lat, v[i].lat); end
            n_cmp++; if (stalls != v[i].lat) begin n_fail++; $display("FAIL %s[%0d] stall cycles: got %0d expected %0d", opname(v[i].f3), i, stalls, v[i].lat); end
        end
    endtask

    task automatic test_div();
        vec_t v[8];
        int lat, stalls; logic [31:0] d; logic [4:0] r;
        v[0] = '{3'b100, 32'hFFFFFFEC, 32'd6,        32'hFFFFFFFD, 33};
        v[1] = '{3'b110, 32'hFFFFFFEC, 32'd6,        32'hFFFFFFFE, 33};
        v[2] = '{3'b101, 32'd100,      32'd7,        32'd14,       33};
        v[3] = '{3'b111, 32'd100,      32'd7,        32'd2,        33};
        v[4] = '{3'b100, 32'd20,       32'hFFFFFFFA, 32'hFFFFFFFD, 33};
        v[5] = '{3'b110, 32'd20,       32'hFFFFFFFA, 32'd2,        33};
        v[6] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33};
        v[7] = '{3'b111, 32'hFFFFFFFF, 32'd16,       32'd15,       33};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            issue_op(v[i].f3, v[i].a, v[i].b, 5'(12 + i), lat, d, r, stalls);
            n_cmp++; if (d !== v[i].exp) begin n_fail++; $display("FAIL %s[%0d] data: got %h expected %h", opname(v[i].f3), i, d, v[i].exp); end
            n_cmp++; if (r !== 5'(12 + i)) begin n_fail++; $display("FAIL %s[%0d] rd: got %0d expected %0d", opname(v[i].f3), i, r, 12 + i); end
            n_cmp++; if (lat != v[i].lat) begin n_fail++; $display("FAIL %s[%0d] latency: got %0d expected %0d", opname(v[i].f3), i, lat, v[i].lat); end
            n_cmp++; if (stalls != v[i].lat) begin n_fail++; $display("FAIL %s[%0d] stall cycles: got %0d expected %0d", opname(v[i].f3), i, stalls, v[i].lat); end
        end
    endtask

    task automatic test_special();
        vec_t v[6];
        int lat, stalls; logic [31:0] d; logic [4:0] r;
        v[0] = '{3'b101, 32'd100,      32'd0,        32'hFFFFFFFF, 1};
        v[1] = '{3'b111, 32'd100,      32'd0,        32'd100,      1};
        v[2] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        v[3] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
        v[4] = '{3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1};
        v[5] = '{3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            issue_op(v[i].f3, v[i].a, v[i].b, 5'(21 + i), lat, d, r, stalls);
            n_cmp++; if (d !== v[i].exp) begin n_fail++; $display("FAIL special %s[%0d] data: got %h expected %h", opname(v[i].f3), i, d, v[i].exp); end
            n_cmp++; if (r !== 5'(21 + i)) begin n_fail++; $display("FAIL special %s[%0d] rd: got %0d expected %0d", opname(v[i].f3), i, r, 21 + i); end
            n_cmp++; if (lat != v[i].lat) begin n_fail++; $display("FAIL special %s[%0d] latency: got %0d expected %0d", opname(v[i].f3), i, lat, v[i].lat); end
            n_cmp++; if (stalls != v[i].lat) begin n_fail++; $display("FAIL special %s[%0d] stall cycles: got %0d expected %0d", opname(v[i].f3), i, stalls, v[i].lat); end
        end
    endtask

    task automatic test_flush();
        int wens, stalls;
        wens = 0; stalls = 0;
        @(negedge clk);
        inst_i = rtype(F7M, 3'b100, 5'd9); op1_i = 32'hFFFFFFEC; op2_i = 32'd6; rd_addr_i = 5'd9;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk); #1;
            if (reg_wen_o) wens++;
        end
        n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL flush busy before flush: got %b expected 1", busy_o); end
        flush_i = 1'b1; inst_i = rtype(7'b0000000, 3'b000, 5'd3);
        @(negedge clk);
        flush_i = 1'b0; #1;
        n_cmp++; if (busy_o !== 1'b0)  begin n_fail++; $display("FAIL flush busy after: got %b expected 0", busy_o); end
        n_cmp++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL flush stall with ADD: got %b expected 0", stall_o); end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            if (reg_wen_o) wens++;
            if (stall_o || busy_o) stalls++;
        end
        n_cmp++; if (wens != 0)   begin n_fail++; $display("FAIL flush write pulses: got %0d expected 0", wens); end
        n_cmp++; if (stalls != 0) begin n_fail++; $display("FAIL flush ADD stall/busy cycles: got %0d expected 0", stalls); end
        inst_i = NOP;
    endtask

    task automatic test_reset_mid();
        int wens;
        wens = 0;
        @(negedge clk);
        inst_i = rtype(F7M, 3'b000, 5'd4); op1_i = 32'd9; op2_i = 32'd9; rd_addr_i = 5'd4;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (stall_o !== 1'b0)    begin n_fail++; $display("FAIL midreset stall_o: got %b expected 0", stall_o); end
        n_cmp++; if (busy_o !== 1'b0)     begin n_fail++; $display("FAIL midreset busy_o: got %b expected 0", busy_o); end
        n_cmp++; if (reg_wen_o !== 1'b0)  begin n_fail++; $display("FAIL midreset reg_wen_o: got %b expected 0", reg_wen_o); end
        n_cmp++; if (rd_addr_o !== 5'd0)  begin n_fail++; $display("FAIL midreset rd_addr_o: got %0d expected 0", rd_addr_o); end
        n_cmp++; if (rd_data_o !== 32'd0) begin n_fail++; $display("FAIL midreset rd_data_o: got %h expected 0", rd_data_o); end
        rst = 1'b0; inst_i = NOP;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            if (reg_wen_o) wens++;
        end
        n_cmp++; if (wens != 0) begin n_fail++; $display("FAIL midreset write pulses: got %0d expected 0", wens); end
    endtask

    task automatic test_back_to_back();
        int k1, k2; logic [31:0] d1, d2; logic [4:0] r1, r2;
        k1 = -1; k2 = -1; d1 = '0; d2 = '0; r1 = '0; r2 = '0;
        @(negedge clk);
        inst_i = rtype(F7M, 3'b000, 5'd10); op1_i = 32'd3; op2_i = 32'd5; rd_addr_i = 5'd10;
        for (int k = 1; k <= 120 && k2 < 0; k++) begin
            @(negedge clk); #1;
            if (reg_wen_o) begin
                if (k1 < 0) begin
                    k1 = k; d1 = rd_data_o; r1 = rd_addr_o;
                    inst_i = rtype(F7M, 3'b000, 5'd11); op1_i = 32'd6; op2_i = 32'd7; rd_addr_i = 5'd11;
                end else begin
                    k2 = k; d2 = rd_data_o; r2 = rd_addr_o;
                end
            end
        end
        inst_i = NOP;
        n_cmp++; if (k1 != MUL_LAT)           begin n_fail++; $display("FAIL b2b first latency: got %0d expected %0d", k1, MUL_LAT); end
        n_cmp++; if (k2 - k1 != MUL_LAT + 1)  begin n_fail++; $display("FAIL b2b pulse spacing: got %0d expected %0d", k2 - k1, MUL_LAT + 1); end
        n_cmp++; if (d1 !== 32'd15 || r1 !== 5'd10) begin n_fail++; $display("FAIL b2b first result: got %h rd %0d expected 0000000f rd 10", d1, r1); end
        n_cmp++; if (d2 !== 32'd42 || r2 !== 5'd11) begin n_fail++; $display("FAIL b2b second result: got %h rd %0d expected 0000002a rd 11", d2, r2); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit in the EX stage, fed by the ID/EX pipeline register outputs.
- Accepts an M-extension instruction presented by ID/EX and holds the front of the pipeline via `stall_o` while it computes.
- Returns a single-cycle register write-back (rd address, data, enable) to the EX/WB path.
- The base EX datapath gates off its own write enable for M-extension opcodes, so this block is the sole writer for them.

## Interface
Parameters:
- `XLEN`, 32: operand/result width. Only 32 is supported.
- `ITER`, 32: iterations per multi-cycle operation. Must equal `XLEN`.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `inst_i` in 32: instruction from ID/EX.
- `op1_i` in 32: rs1 value from ID/EX.
- `op2_i` in 32: rs2 value from ID/EX.
- `rd_addr_i` in 5: destination register from ID/EX.
- `flush_i` in 1: pipeline flush (taken jump/branch); aborts any operation in progress.
- `stall_o` out 1: hold IF/ID and ID/EX.
- `busy_o` out 1: FSM not in IDLE.
- `rd_addr_o` out 5: write-back register address.
- `rd_data_o` out 32: write-back data.
- `reg_wen_o` out 1: write-back enable, one-cycle pulse.

## Operation
- **Decode:** M-op when `inst_i[6:0]==7'b0110011` and `inst_i[31:25]==7'b0000001`. `funct3 = inst_i[14:12]` selects MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- **FSM states:** IDLE, BUSY, DONE.
- **IDLE → BUSY:** on an M-op with `flush_i=0`.
  - Latch the op, `rd_addr_i`, operand magnitudes and the result sign.
  - Load the counter with `ITER`.
- **IDLE → DONE directly:** for the special cases below (result latched on entry).
- **BUSY:**
  - One shift-add (mul) or restoring shift-subtract (div) step per cycle; counter decrements.
  - Moves to DONE when the counter reaches 0.
- **DONE:** drive the result with `reg_wen_o=1` for exactly one cycle, then go to IDLE unconditionally. `inst_i` is ignored in DONE, because ID/EX still holds the same instruction.
- **Signed handling:**
  - Operate on absolute values.
  - Negate the 64-bit product when the operand signs differ (MULH: both signed; MULHSU: rs1 only).
  - Quotient sign = sign(op1) XOR sign(op2). Remainder sign = sign(op1).
- **Result selection:**
  - MUL returns product[31:0]; MULH* return product[63:32].
  - DIV* return the quotient; REM* return the remainder.
- **Special cases** (no iteration, IDLE→DONE):
  - Divisor 0: DIV/DIVU return 32'hFFFFFFFF; REM/REMU return op1.
  - DIV with op1=32'h80000000, op2=32'hFFFFFFFF: returns 32'h80000000. REM with the same operands returns 0.
- **flush_i=1:**
  - Forces IDLE next cycle from any state; no write-back occurs.
  - If asserted in DONE, `reg_wen_o` is suppressed in that same cycle.
  - Flush has priority over start.
- **Reset:** `rst` has the highest priority, mid-operation included.

## Timing
- **Reset values:** state=IDLE, `stall_o=0`, `busy_o=0`, `rd_addr_o=0`, `rd_data_o=0`, `reg_wen_o=0`, counter=0.
- **`stall_o`** = (IDLE AND M-op AND !flush_i) OR BUSY.
  - It is combinational in the acceptance cycle T, so ID/EX holds.
  - It is 0 in DONE, so ID/EX advances at the end of DONE.
- **Iterative op accepted at edge ending cycle T:**
  - BUSY for cycles T+1..T+32.
  - DONE in T+33, which carries `reg_wen_o=1`.
  - Total stall is 33 cycles (T..T+32).
- **Special case:** DONE in T+1, stall 1 cycle.
- **Outputs in DONE:** `rd_addr_o`/`rd_data_o` are registered and valid only while `reg_wen_o=1`. Both hold their last value otherwise.
- **Back-to-back M-ops:** the second M-op is accepted in the IDLE cycle after DONE (one bubble).
- **Non-M instruction in IDLE:** no state change, `stall_o=0`.

## Configuration
- **`MULDIV_FAST_MUL_EN` defined:**
  - MUL/MULH/MULHSU/MULHU are computed combinationally with a 33x33 signed multiply.
  - Path is IDLE→DONE, stall 1 cycle, result in T+1.
- **Undefined:** multiplies use the 32-iteration shift-add path (result in T+33).
- **Divides** are iterative in both builds.

## Test plan
- MUL 7 × (−3): `op1=7`, `op2=32'hFFFFFFFD`, rd=5 → `reg_wen_o=1`, rd=5, data 32'hFFFFFFEB, in T+33 (T+1 with `MULDIV_FAST_MUL_EN`). `stall_o` high exactly T..T+32.
- MULHU 32'hFFFFFFFF × 32'hFFFFFFFF → 32'hFFFFFFFE. MULHSU on the same operands → 32'hFFFFFFFF.
- DIV −20 / 6 → 32'hFFFFFFFD. REM on the same operands → 32'hFFFFFFFE. Both at T+33.
- DIVU 100 / 0 → 32'hFFFFFFFF at T+1. REMU 100 / 0 → 100. DIV 32'h80000000 / −1 → 32'h80000000 at T+1.
- `flush_i` pulsed at T+10 of a DIV → IDLE at T+11, `stall_o=0`, and no `reg_wen_o` pulse for that op. A following ADD is not stalled.
- `rst` asserted at T+5 of a MUL → all outputs 0 next cycle. Two back-to-back MULs → two write pulses, 34 cycles apart.
